// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management bus between the reconfig sequencer and the PLL reconfig core.
interface pll_reconfig_seq_if;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] mgmt_address;
    logic              mgmt_write;
    logic [DATA_W-1:0] mgmt_writedata;
    logic              mgmt_waitrequest;

    modport master (
        output mgmt_address,
        output mgmt_write,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );
endinterface

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: writes mode/N/M/[K]/C0/C1/start to the reconfig
// core, then waits for a stable PLL lock and reports done or lock timeout.
module pll_reconfig_seq #(
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 2000000,
    parameter int unsigned CNT_W        = 22
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [17:0]               cfg_n,
    input  logic [17:0]               cfg_m,
    input  logic [31:0]               cfg_k,
    input  logic                      cfg_frac,
    input  logic [17:0]               cfg_c0,
    input  logic [17:0]               cfg_c1,
    pll_reconfig_seq_if.master        mgmt,
    input  logic                      pll_locked,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      locked_ok
);
    localparam int unsigned CFG_W  = 18;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;

    localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, W_MODE, W_N, W_M, W_K, W_C0, W_C1, W_START, WAIT_LOCK
    } state_t;

    state_t state, state_n;

    logic              lk_meta, lk_s;
    logic [CNT_W-1:0]  stab, stab_n;
    logic [CNT_W-1:0]  tmo, tmo_n;
    logic              busy_n, done_n, error_n, ready_n, locked_ok_n;
    logic              wr_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic              accept;

    logic [CFG_W-1:0]  n_q, m_q, c0_q, c1_q;
    logic [31:0]       k_q;
    logic              frac_q;

    assign accept = (state == IDLE) && cfg_valid && cfg_ready;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    // Capture the request so later input changes cannot disturb the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q    <= '0;
            m_q    <= '0;
            k_q    <= '0;
            frac_q <= 1'b0;
            c0_q   <= '0;
            c1_q   <= '0;
        end else if (accept) begin
            n_q    <= cfg_n;
            m_q    <= cfg_m;
            k_q    <= cfg_k;
            frac_q <= cfg_frac;
            c0_q   <= cfg_c0;
            c1_q   <= cfg_c1;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            stab                <= '0;
            tmo                 <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            locked_ok           <= 1'b0;
            cfg_ready           <= 1'b1;
            mgmt.mgmt_write     <= 1'b0;
            mgmt.mgmt_address   <= '0;
            mgmt.mgmt_writedata <= '0;
        end else begin
            state               <= state_n;
            stab                <= stab_n;
            tmo                 <= tmo_n;
            busy                <= busy_n;
            done                <= done_n;
            error               <= error_n;
            locked_ok           <= locked_ok_n;
            cfg_ready           <= ready_n;
            mgmt.mgmt_write     <= wr_n;
            mgmt.mgmt_address   <= addr_n;
            mgmt.mgmt_writedata <= data_n;
        end
    end

    // Next-state logic, counters, and the bus word presented in the next state.
    always_comb begin
        state_n = state;
        busy_n  = busy;
        done_n  = 1'b0;
        error_n = error;
        tmo_n   = tmo;
        wr_n    = 1'b0;
        addr_n  = '0;
        data_n  = '0;

        if (!lk_s) begin
            stab_n = '0;
        end else if (stab != STAB_MAX) begin
            stab_n = stab + CNT_W'(1);
        end else begin
            stab_n = stab;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = W_MODE;
                    busy_n  = 1'b1;
                    error_n = 1'b0;
                end
            end
            W_MODE:  if (!mgmt.mgmt_waitrequest) state_n = W_N;
            W_N:     if (!mgmt.mgmt_waitrequest) state_n = W_M;
            W_M:     if (!mgmt.mgmt_waitrequest) state_n = frac_q ? W_K : W_C0;
            W_K:     if (!mgmt.mgmt_waitrequest) state_n = W_C0;
            W_C0:    if (!mgmt.mgmt_waitrequest) state_n = W_C1;
            W_C1:    if (!mgmt.mgmt_waitrequest) state_n = W_START;
            W_START: begin
                // Start completes only once the core has finished reconfiguring.
                if (!mgmt.mgmt_waitrequest) begin
                    state_n = WAIT_LOCK;
                    tmo_n   = '0;
                    stab_n  = '0;
                end
            end
            WAIT_LOCK: begin
                tmo_n = tmo + CNT_W'(1);
                if (locked_ok) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else if (tmo == TMO_LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    error_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        locked_ok_n = (stab_n == STAB_MAX);
        // Ready reopens one cycle after the done pulse.
        ready_n     = (state_n == IDLE) && (state == IDLE);

        case (state_n)
            W_MODE:  begin wr_n = 1'b1; addr_n = 6'd0; data_n = 32'd0; end
            W_N:     begin wr_n = 1'b1; addr_n = 6'd3; data_n = {14'b0, n_q}; end
            W_M:     begin wr_n = 1'b1; addr_n = 6'd4; data_n = {14'b0, m_q}; end
            W_K:     begin wr_n = 1'b1; addr_n = 6'd7; data_n = k_q; end
            W_C0:    begin wr_n = 1'b1; addr_n = 6'd5; data_n = {9'b0, 5'd0, c0_q}; end
            W_C1:    begin wr_n = 1'b1; addr_n = 6'd5; data_n = {9'b0, 5'd1, c1_q}; end
            W_START: begin wr_n = 1'b1; addr_n = 6'd2; data_n = 32'd1; end
            default: begin wr_n = 1'b0; addr_n = '0;   data_n = '0; end
        endcase
    end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Testbench for pll_reconfig_seq: directed and randomized requests against a
// transaction-level model of the expected register writes and lock timing.
module tb_pll_reconfig_seq;
    localparam int unsigned LS = 16;
    localparam int unsigned LT = 200;

    logic        clk, rst_n;
    logic        cfg_valid, cfg_ready, cfg_frac;
    logic [17:0] cfg_n, cfg_m, cfg_c0, cfg_c1;
    logic [31:0] cfg_k;
    logic        pll_locked, busy, done, error, locked_ok;

    pll_reconfig_seq_if mgmt_if();

    pll_reconfig_seq #(.LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .CNT_W(22)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_frac(cfg_frac),
        .cfg_c0(cfg_c0), .cfg_c1(cfg_c1),
        .mgmt(mgmt_if),
        .pll_locked(pll_locked),
        .busy(busy), .done(done), .error(error), .locked_ok(locked_ok)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [37:0] got_q[$];
    logic [37:0] exp_q[$];
    int   start_cyc, done_cyc = -100, wn_acc, wm_first, done_cnt;
    bit   start_seen;
    logic done_busy, done_err, done_rdy, rdy_after;
    logic prev_stall = 1'b0;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    int   wr_mode = 0;
    int   stall_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waitrequest driver: 0 idle-low, 1 random, 2 stall W_N five cycles, 3 stall W_M forever.
    always @(posedge clk) begin
        #1;
        case (wr_mode)
            1: mgmt_if.mgmt_waitrequest = ($urandom_range(0, 2) == 0);
            2: begin
                if (mgmt_if.mgmt_write && mgmt_if.mgmt_address == 6'd3 && stall_cnt < 5) begin
                    mgmt_if.mgmt_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mgmt_if.mgmt_waitrequest = 1'b0;
                end
            end
            3: mgmt_if.mgmt_waitrequest = mgmt_if.mgmt_write && (mgmt_if.mgmt_address == 6'd4);
            default: mgmt_if.mgmt_waitrequest = 1'b0;
        endcase
    end

    // Bus and status monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_write_held", 64'(mgmt_if.mgmt_write), 64'd1);
                check("stall_addr_held", 64'(mgmt_if.mgmt_address), 64'(prev_addr));
                check("stall_data_held", 64'(mgmt_if.mgmt_writedata), 64'(prev_data));
            end
            prev_stall = mgmt_if.mgmt_write && mgmt_if.mgmt_waitrequest;
            prev_addr  = mgmt_if.mgmt_address;
            prev_data  = mgmt_if.mgmt_writedata;
            if (mgmt_if.mgmt_write && !mgmt_if.mgmt_waitrequest) begin
                got_q.push_back({mgmt_if.mgmt_address, mgmt_if.mgmt_writedata});
                if (mgmt_if.mgmt_address == 6'd2) begin
                    start_cyc  = cyc;
                    start_seen = 1'b1;
                end
                if (mgmt_if.mgmt_address == 6'd3) wn_acc = cyc;
            end
            if (mgmt_if.mgmt_write && mgmt_if.mgmt_address == 6'd4 && wm_first < 0) wm_first = cyc;
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
                done_err  = error;
                done_rdy  = cfg_ready;
            end
            if (cyc == done_cyc + 1) rdy_after = cfg_ready;
        end
    end

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        start_seen = 1'b0;
        start_cyc  = -1;
        done_cnt   = 0;
        done_cyc   = -100;
        wn_acc     = -1;
        wm_first   = -1;
    endtask

    // Reference write list derived from the register map.
    task automatic build_exp(input logic [17:0] n, input logic [17:0] m, input logic [31:0] k,
                             input logic frac, input logic [17:0] c0, input logic [17:0] c1);
        exp_q.push_back({6'd0, 32'd0});
        exp_q.push_back({6'd3, 32'(n)});
        exp_q.push_back({6'd4, 32'(m)});
        if (frac) exp_q.push_back({6'd7, k});
        exp_q.push_back({6'd5, 32'(c0)});
        exp_q.push_back({6'd5, 32'(c1) | 32'h0004_0000});
        exp_q.push_back({6'd2, 32'd1});
    endtask

    task automatic do_req(input logic [17:0] n, input logic [17:0] m, input logic [31:0] k,
                          input logic frac, input logic [17:0] c0, input logic [17:0] c1,
                          input bit hold);
        bit acc = 1'b0;
        cfg_n = n; cfg_m = m; cfg_k = k; cfg_frac = frac; cfg_c0 = c0; cfg_c1 = c1;
        cfg_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = cfg_ready;
            @(posedge clk); #1;
        end
        check("req_accepted", 64'(acc), 64'd1);
        build_exp(n, m, k, frac, c0, c1);
        check("busy_on_accept", 64'(busy), 64'd1);
        check("ready_low_busy", 64'(cfg_ready), 64'd0);
        cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_k = $urandom;
        cfg_frac = 1'($urandom); cfg_c0 = 18'($urandom); cfg_c1 = 18'($urandom);
        if (hold) begin
            repeat (3) @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) ok = 1'b1;
        end
        check("done_seen", 64'(ok), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("done_single_pulse", 64'(done_cnt), 64'd1);
    endtask

    task automatic cmp_writes(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int tgt;
        bit ok;
        logic fr;
        rst_n = 1'b1; cfg_valid = 1'b0; cfg_n = '0; cfg_m = '0; cfg_k = '0; cfg_frac = 1'b0;
        cfg_c0 = '0; cfg_c1 = '0; pll_locked = 1'b0; mgmt_if.mgmt_waitrequest = 1'b0;
        clear_mon();
        #1 rst_n = 1'b0;
        #1;
        check("rst_write", 64'(mgmt_if.mgmt_write), 64'd0);
        check("rst_addr", 64'(mgmt_if.mgmt_address), 64'd0);
        check("rst_data", 64'(mgmt_if.mgmt_writedata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_locked_ok", 64'(locked_ok), 64'd0);
        check("rst_ready", 64'(cfg_ready), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(cfg_ready), 64'd1);
        check("locked_ok_unlocked", 64'(locked_ok), 64'd0);

        pll_locked = 1'b1;
        repeat (LS + 4) @(posedge clk);
        #1;
        check("locked_ok_stable", 64'(locked_ok), 64'd1);

        // Basic directed sequence with fractional K.
        clear_mon(); wr_mode = 0;
        do_req(18'h00404, 18'h01010, 32'h8000_0000, 1'b1, 18'h00303, 18'h00505, 1'b0);
        wait_done(LT + 100);
        cmp_writes("basic");
        check("basic_latency", 64'(done_cyc - start_cyc), 64'(LS + 2));
        check("basic_error", 64'(done_err), 64'd0);
        check("basic_busy_at_done", 64'(done_busy), 64'd0);
        check("basic_ready_at_done", 64'(done_rdy), 64'd0);
        check("basic_ready_after", 64'(rdy_after), 64'd1);

        // Integer mode: K register skipped.
        clear_mon();
        do_req(18'($urandom), 18'($urandom), $urandom, 1'b0, 18'($urandom), 18'($urandom), 1'b0);
        wait_done(LT + 100);
        cmp_writes("nofrac");
        check("nofrac_latency", 64'(done_cyc - start_cyc), 64'(LS + 2));

        // Five-cycle stall on the N write.
        clear_mon(); stall_cnt = 0; wr_mode = 2;
        do_req(18'($urandom), 18'($urandom), $urandom, 1'b1, 18'($urandom), 18'($urandom), 1'b0);
        wait_done(LT + 100);
        cmp_writes("stall");
        check("stall_cycles", 64'(stall_cnt), 64'd5);
        check("stall_next_write", 64'(wm_first - wn_acc), 64'd1);

        // Random requests with random waitrequest; valid held into busy is ignored.
        wr_mode = 1;
        for (int it = 0; it < 4; it++) begin
            clear_mon();
            fr = 1'($urandom);
            do_req(18'($urandom), 18'($urandom), $urandom, fr, 18'($urandom), 18'($urandom), 1'b1);
            wait_done(LT + 300);
            cmp_writes($sformatf("rand%0d", it));
            check($sformatf("rand%0d_latency", it), 64'(done_cyc - start_cyc), 64'(LS + 2));
            check($sformatf("rand%0d_error", it), 64'(done_err), 64'd0);
        end

        // Lock never arrives: timeout, sticky error, cleared by the next request.
        wr_mode = 0; pll_locked = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        clear_mon();
        do_req(18'($urandom), 18'($urandom), $urandom, 1'b1, 18'($urandom), 18'($urandom), 1'b0);
        wait_done(LT + 100);
        check("tmo_latency", 64'(done_cyc - start_cyc), 64'(LT + 1));
        check("tmo_error_at_done", 64'(done_err), 64'd1);
        check("tmo_error_sticky", 64'(error), 64'd1);
        pll_locked = 1'b1;
        clear_mon();
        do_req(18'($urandom), 18'($urandom), $urandom, 1'b0, 18'($urandom), 18'($urandom), 1'b0);
        check("tmo_error_cleared", 64'(error), 64'd0);
        wait_done(LT + 100);
        check("tmo_recover_error", 64'(done_err), 64'd0);
        check("tmo_recover_latency", 64'(done_cyc - start_cyc), 64'(LS + 2));

        // One-cycle lock drop halfway through qualification.
        clear_mon();
        do_req(18'($urandom), 18'($urandom), $urandom, 1'b1, 18'($urandom), 18'($urandom), 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = start_seen;
        end
        check("glitch_start_seen", 64'(ok), 64'd1);
        tgt = start_cyc + 1 + int'(LS / 2);
        for (int i = 0; i < 100 && cyc < tgt; i++) begin
            @(posedge clk); #1;
        end
        pll_locked = 1'b0;
        @(posedge clk); #1;
        pll_locked = 1'b1;
        wait_done(LT + 100);
        // The low sample reaches the synchronized lock two cycles later, then LS clean cycles.
        check("glitch_done_cycle", 64'(done_cyc), 64'(tgt + int'(LS) + 4));
        check("glitch_error", 64'(done_err), 64'd0);

        // Asynchronous reset while the M write is stalled.
        clear_mon(); wr_mode = 3;
        do_req(18'($urandom), 18'($urandom), $urandom, 1'b1, 18'($urandom), 18'($urandom), 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            ok = mgmt_if.mgmt_write && (mgmt_if.mgmt_address == 6'd4);
        end
        check("rst_mid_wm_reached", 64'(ok), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_write", 64'(mgmt_if.mgmt_write), 64'd0);
        check("mid_rst_addr", 64'(mgmt_if.mgmt_address), 64'd0);
        check("mid_rst_data", 64'(mgmt_if.mgmt_writedata), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_locked_ok", 64'(locked_ok), 64'd0);
        check("mid_rst_ready", 64'(cfg_ready), 64'd1);
        wr_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ready_after", 64'(cfg_ready), 64'd1);
        clear_mon();
        do_req(18'($urandom), 18'($urandom), $urandom, 1'b1, 18'($urandom), 18'($urandom), 1'b0);
        wait_done(LT + 100);
        cmp_writes("restart");
        check("restart_error", 64'(done_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
